// File: rtl/addr_decoder_seq.sv
// Address decoder with a one-hot registered select output. Either decodes a direct
// address request or sweeps every word in ascending order. The sweep can be paused.
module addr_decoder_seq #(
  parameter int unsigned ADDR_W = 2,
  localparam int unsigned WORDS = 2 ** ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              en_i,
  input  logic              scan_start_i,
  input  logic              scan_hold_i,
  output logic [WORDS-1:0]  sel_o,
  output logic              sel_valid_o,
  output logic [ADDR_W-1:0] scan_addr_o,
  output logic              busy_o,
  output logic              scan_done_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // The sweep counter is one bit wider than an address so that "every word presented"
  // can be seen directly, without the counter wrapping.
  localparam logic [ADDR_W:0] CntEnd = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CntOne = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        r_state, w_state_d;
  logic [ADDR_W:0]   r_cnt, w_cnt_d;      // next word the sweep will present
  logic [ADDR_W-1:0] r_addr, w_addr_d;    // word presented, held across paused cycles
  logic [WORDS-1:0]  r_sel, w_sel_d;
  logic              r_valid, w_valid_d;
  logic              r_done, w_done_d;
  logic [ADDR_W-1:0] w_dec_idx;
  logic [WORDS-1:0]  w_dec;

  // Pick the index to decode: the sweep counter, word 0 on sweep start, or the direct address.
  always_comb begin
    if (r_state == StScan) begin
      w_dec_idx = r_cnt[ADDR_W-1:0];
    end else if (scan_start_i) begin
      w_dec_idx = '0;
    end else begin
      w_dec_idx = addr_i;
    end
  end

  // Binary-to-one-hot decode.
  always_comb begin
    w_dec            = '0;
    w_dec[w_dec_idx] = 1'b1;
  end

  // Next-state and next-output logic; select outputs default to idle/zero each cycle.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_addr_d  = r_addr;
    w_sel_d   = '0;
    w_valid_d = 1'b0;
    w_done_d  = 1'b0;
    case (r_state)
      StIdle: begin
        w_cnt_d  = '0;
        w_addr_d = '0;
        if (scan_start_i) begin
          // Sweep start wins over a simultaneous direct request; word 0 goes out at once.
          w_state_d = StScan;
          w_sel_d   = w_dec;
          w_valid_d = 1'b1;
          w_cnt_d   = CntOne;
        end else if (en_i) begin
          w_sel_d   = w_dec;
          w_valid_d = 1'b1;
        end
      end
      StScan: begin
        if (r_cnt == CntEnd) begin
          // Last word has been presented; finish even if a pause is requested.
          w_state_d = StDone;
          w_done_d  = 1'b1;
          w_cnt_d   = '0;
          w_addr_d  = '0;
        end else if (!scan_hold_i) begin
          w_sel_d   = w_dec;
          w_valid_d = 1'b1;
          w_addr_d  = r_cnt[ADDR_W-1:0];
          w_cnt_d   = r_cnt + CntOne;
        end
      end
      StDone: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
        w_addr_d  = '0;
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
        w_addr_d  = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_addr  <= w_addr_d;
      r_sel   <= w_sel_d;
      r_valid <= w_valid_d;
      r_done  <= w_done_d;
    end
  end

  assign sel_o       = r_sel;
  assign sel_valid_o = r_valid;
  assign scan_addr_o = r_addr;
  assign busy_o      = (r_state == StScan);
  assign scan_done_o = r_done;

endmodule

// File: tb/tb_addr_decoder_seq.sv
// Directed bench for addr_decoder_seq; three instances (ADDR_W = 1, 2, 3) share the controls.
module tb_addr_decoder_seq;

  logic       clk = 1'b0;
  logic       rst, en, start, hold;
  logic [2:0] addr;

  logic [1:0] s1_sel; logic s1_val; logic [0:0] s1_sa; logic s1_busy, s1_done;
  logic [3:0] s2_sel; logic s2_val; logic [1:0] s2_sa; logic s2_busy, s2_done;
  logic [7:0] s3_sel; logic s3_val; logic [2:0] s3_sa; logic s3_busy, s3_done;

  int total = 0;
  int bad   = 0;
  int busy_cnt;
  bit live  = 1'b0;

  // Sweep with start held high (ignored in SCAN and DONE), ADDR_W=2 and ADDR_W=1 views.
  logic [3:0] e2_sel  [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
  logic [1:0] e2_sa   [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
  logic       e2_busy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       e2_done [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [1:0] e1_sel  [4] = '{2'b01, 2'b10, 2'b00, 2'b00};
  logic       e1_busy [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic       e1_done [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  // ADDR_W=3 sweep paused for two cycles after word 3.
  logic [7:0] e3_sel  [12] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 8'h00,
                               8'h10, 8'h20, 8'h40, 8'h80, 8'h00, 8'h00};
  logic [2:0] e3_sa   [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3,
                               3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd0};
  logic       e3_done [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  addr_decoder_seq #(.ADDR_W(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr[0:0]), .en_i(en), .scan_start_i(start),
    .scan_hold_i(hold), .sel_o(s1_sel), .sel_valid_o(s1_val), .scan_addr_o(s1_sa),
    .busy_o(s1_busy), .scan_done_o(s1_done)
  );

  addr_decoder_seq #(.ADDR_W(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr[1:0]), .en_i(en), .scan_start_i(start),
    .scan_hold_i(hold), .sel_o(s2_sel), .sel_valid_o(s2_val), .scan_addr_o(s2_sa),
    .busy_o(s2_busy), .scan_done_o(s2_done)
  );

  addr_decoder_seq #(.ADDR_W(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .en_i(en), .scan_start_i(start),
    .scan_hold_i(hold), .sel_o(s3_sel), .sel_valid_o(s3_val), .scan_addr_o(s3_sa),
    .busy_o(s3_busy), .scan_done_o(s3_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every cycle: select is one-hot or zero, and nonzero exactly when valid is high.
  task automatic inv();
    logic [1:0] r;
    r = {$onehot0(s1_sel), ((|s1_sel) === s1_val)};
    chk("inv_w1", 32'(r), 32'd3);
    r = {$onehot0(s2_sel), ((|s2_sel) === s2_val)};
    chk("inv_w2", 32'(r), 32'd3);
    r = {$onehot0(s3_sel), ((|s3_sel) === s3_val)};
    chk("inv_w3", 32'(r), 32'd3);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (live) inv();
  endtask

  task automatic chk_zero2(input string tag);
    chk({tag, "_sel"},  32'(s2_sel),  32'd0);
    chk({tag, "_val"},  32'(s2_val),  32'd0);
    chk({tag, "_sa"},   32'(s2_sa),   32'd0);
    chk({tag, "_busy"}, 32'(s2_busy), 32'd0);
    chk({tag, "_done"}, 32'(s2_done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b0; hold = 1'b0; addr = 3'd0;
    step();
    live = 1'b1;
    chk_zero2("reset");
    chk("reset_sel3",  32'(s3_sel),  32'd0);
    chk("reset_done1", 32'(s1_done), 32'd0);
    rst = 1'b0;

    // Direct decode, one-cycle latency.
    en = 1'b1; addr = 3'd2;
    step();
    chk("dir2_sel", 32'(s2_sel), 32'h4);
    chk("dir2_val", 32'(s2_val), 32'd1);
    chk("dir3_sel", 32'(s3_sel), 32'h04);
    addr = 3'd5;
    step();
    chk("dir5_sel2", 32'(s2_sel), 32'h2);
    chk("dir5_sel3", 32'(s3_sel), 32'h20);
    chk("dir5_sa3",  32'(s3_sa),  32'd0);
    addr = 3'd3;
    step();
    chk("dir3_sel2", 32'(s2_sel), 32'h8);
    en = 1'b0;
    step();
    chk("dir_off_sel", 32'(s2_sel), 32'd0);
    chk("dir_off_val", 32'(s2_val), 32'd0);

    // Sweep; start/en stay high through SCAN and DONE and must be ignored there.
    start = 1'b1; en = 1'b1; addr = 3'd3;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("sw2_sel_c%0d", i),  32'(s2_sel),  32'(e2_sel[i]));
      chk($sformatf("sw2_sa_c%0d", i),   32'(s2_sa),   32'(e2_sa[i]));
      chk($sformatf("sw2_busy_c%0d", i), 32'(s2_busy), 32'(e2_busy[i]));
      chk($sformatf("sw2_done_c%0d", i), 32'(s2_done), 32'(e2_done[i]));
      if (i < 4) begin
        chk($sformatf("sw1_sel_c%0d", i),  32'(s1_sel),  32'(e1_sel[i]));
        chk($sformatf("sw1_busy_c%0d", i), 32'(s1_busy), 32'(e1_busy[i]));
        chk($sformatf("sw1_done_c%0d", i), 32'(s1_done), 32'(e1_done[i]));
      end
    end

    // Reset overrides start and en in the same cycle.
    rst = 1'b1;
    step();
    chk_zero2("rst_ovr");
    chk("rst_ovr_busy3", 32'(s3_busy), 32'd0);
    rst = 1'b0; start = 1'b0; en = 1'b0;
    step();

    // Start and direct request together: sweep wins, no direct select.
    start = 1'b1; en = 1'b1; addr = 3'd3;
    step();
    chk("prio_sel",  32'(s2_sel),  32'h1);
    chk("prio_sa",   32'(s2_sa),   32'd0);
    chk("prio_busy", 32'(s2_busy), 32'd1);
    start = 1'b0; en = 1'b0;
    step();
    chk("prio_sel_c1", 32'(s2_sel), 32'h2);
    step();
    chk("prio_sa_c2", 32'(s2_sa), 32'd2);

    // Reset mid-sweep aborts with no done pulse.
    rst = 1'b1;
    step();
    chk_zero2("abort");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("abort_done_c%0d", i), 32'(s2_done), 32'd0);
      chk($sformatf("abort_busy_c%0d", i), 32'(s2_busy), 32'd0);
    end

    // ADDR_W=3 sweep paused for two cycles after word 3.
    start = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      start = 1'b0;
      if (s3_busy === 1'b1) busy_cnt++;
      chk($sformatf("hold_sel_c%0d", i),  32'(s3_sel),  32'(e3_sel[i]));
      chk($sformatf("hold_sa_c%0d", i),   32'(s3_sa),   32'(e3_sa[i]));
      chk($sformatf("hold_done_c%0d", i), 32'(s3_done), 32'(e3_done[i]));
      hold = (i == 3 || i == 4);
    end
    chk("hold_busy_cycles", 32'(busy_cnt), 32'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
